// File: rtl/sample_half_fifo_if.sv
// sample_half_fifo_if -- write/read handshake bundle for sample_half_fifo.
//   master : sampling side and downstream consumer (drives wr_en, wr_data, rd_en)
//   slave  : the FIFO (drives full, empty, rd_data, rd_valid, above_half, underrun)
interface sample_half_fifo_if #(
  parameter int unsigned DATA_W = 16
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              above_half;
  logic              underrun;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, rd_data, rd_valid, empty, above_half, underrun
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, rd_data, rd_valid, empty, above_half, underrun
  );
endinterface

// File: rtl/sample_half_fifo.sv
// sample_half_fifo -- circular sample buffer with a half-full stream enable.
// A FILL/RUN state machine raises above_half once the buffer is at least half
// full and holds it (hysteresis) until a read is attempted on an empty buffer,
// which sets the sticky underrun flag and returns to FILL.
//
// Ports:
//   clk      single clock
//   rst_n    asynchronous active-low reset
//   bus      sample_half_fifo_if.slave (wr_en/wr_data/full, rd_en/rd_data/
//            rd_valid/empty, above_half, underrun); all outputs registered
//   drop_cnt 16-bit saturating count of writes rejected while full
//            (present only when SAMPLE_HALF_FIFO_DROP_CNT_EN is defined)
//
// DATA_W must match the interface instance; DEPTH must be a power of two >= 4.
module sample_half_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sample_half_fifo_if.slave    bus
`ifdef SAMPLE_HALF_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic              ur_evt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Accept decisions, post-update count and next FSM state.
  always_comb begin
    wr_acc    = bus.wr_en && !bus.full;
    rd_acc    = bus.rd_en && !bus.empty;
    ur_evt    = (state == RUN) && bus.rd_en && bus.empty;
    count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
    state_nxt = state;
    case (state)
      FILL:    if (count_nxt >= CW'(DEPTH / 2)) state_nxt = RUN;
      RUN:     if (ur_evt) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // FSM state and its registered stream-enable output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FILL;
      bus.above_half <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.above_half <= (state_nxt == RUN);
    end
  end

  // Pointers, occupancy, flags and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.full     <= 1'b0;
      bus.empty    <= 1'b1;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr      <= rd_ptr + AW'(1);
        bus.rd_data <= mem[rd_ptr];
      end
      bus.rd_valid <= rd_acc;
      count        <= count_nxt;
      // Flags track the next count so they are valid the cycle it lands.
      bus.full     <= (count_nxt == CW'(DEPTH));
      bus.empty    <= (count_nxt == '0);
      if (ur_evt) bus.underrun <= 1'b1;
    end
  end

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

`ifdef SAMPLE_HALF_FIFO_DROP_CNT_EN
  // Saturating count of writes lost to a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (bus.wr_en && bus.full && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_half_fifo.sv
// tb_sample_half_fifo -- directed bench for sample_half_fifo (DEPTH=64, DATA_W=16).
module tb_sample_half_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_half_fifo_if #(.DATA_W(DW)) sif ();

`ifdef SAMPLE_HALF_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  sample_half_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
`ifdef SAMPLE_HALF_FIFO_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  // Reference model state.
  logic [DW-1:0] q [$];
  int unsigned   mcnt   = 0;
  bit            m_run  = 1'b0;
  bit            m_und  = 1'b0;
  logic [DW-1:0] m_rd   = '0;
  bit            m_rv   = 1'b0;
  int unsigned   m_drop = 0;

  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;
  int unsigned cyc_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rd_valid",   32'(sif.rd_valid),   32'(m_rv));
    check("rd_data",    32'(sif.rd_data),    32'(m_rd));
    check("full",       32'(sif.full),       32'(mcnt == DEPTH));
    check("empty",      32'(sif.empty),      32'(mcnt == 0));
    check("above_half", 32'(sif.above_half), 32'(m_run));
    check("underrun",   32'(sif.underrun),   32'(m_und));
`ifdef SAMPLE_HALF_FIFO_DROP_CNT_EN
    check("drop_cnt",   32'(drop_cnt),       m_drop);
`endif
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r);
    bit oldfull;
    bit oldempty;
    sif.wr_en   = w;
    sif.wr_data = d;
    sif.rd_en   = r;
    oldfull  = (mcnt == DEPTH);
    oldempty = (mcnt == 0);
    m_rv = 1'b0;
    if (r && !oldempty) begin
      m_rd = q.pop_front();
      m_rv = 1'b1;
    end
    if (w && !oldfull) q.push_back(d);
    mcnt = q.size();
    if (!m_run && mcnt >= DEPTH / 2) m_run = 1'b1;
    else if (m_run && r && oldempty) begin
      m_run = 1'b0;
      m_und = 1'b1;
    end
    if (w && oldfull && m_drop < 65535) m_drop++;
    @(posedge clk);
    #1;
    cyc_no++;
    check_all();
    sif.wr_en = 1'b0;
    sif.rd_en = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    mcnt   = 0;
    m_run  = 1'b0;
    m_und  = 1'b0;
    m_rd   = '0;
    m_rv   = 1'b0;
    m_drop = 0;
  endtask

  initial begin
    sif.wr_en   = 1'b0;
    sif.wr_data = '0;
    sif.rd_en   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all();
    check("rst_empty", 32'(sif.empty), 32'd1);
    rst_n = 1'b1;

    // Fill: above_half stays low through 31 words, rises on the 32nd.
    for (int k = 0; k < 31; k++) cyc(1'b1, DW'(k), 1'b0);
    check("fill31_above_half", 32'(sif.above_half), 32'd0);
    cyc(1'b1, DW'(31), 1'b0);
    check("fill32_above_half", 32'(sif.above_half), 32'd1);

    // Stream: one read and one write per cycle, output 0,1,2,... with no gaps.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, DW'(32 + i), 1'b1);
      check("stream_data",  32'(sif.rd_data),  32'(i));
      check("stream_valid", 32'(sif.rd_valid), 32'd1);
    end

    // Drain 32 words, then one read on empty in RUN.
    for (int j = 0; j < 32; j++) cyc(1'b0, '0, 1'b1);
    check("drain_last", 32'(sif.rd_data), 32'd71);
    check("drain_empty", 32'(sif.empty), 32'd1);
    check("drain_above", 32'(sif.above_half), 32'd1);
    cyc(1'b0, '0, 1'b1);
    check("ur_flag",  32'(sif.underrun),   32'd1);
    check("ur_above", 32'(sif.above_half), 32'd0);
    check("ur_valid", 32'(sif.rd_valid),   32'd0);
    check("ur_hold",  32'(sif.rd_data),    32'd71);

    // Simultaneous read/write at count 0: read rejected, write accepted.
    cyc(1'b1, 16'h0AAA, 1'b1);
    check("rw0_valid", 32'(sif.rd_valid), 32'd0);
    check("rw0_empty", 32'(sif.empty),    32'd0);

    // Overflow: fill to 64, then three rejected writes.
    for (int k = 0; k < 63; k++) cyc(1'b1, DW'(16'h0100 + k), 1'b0);
    check("ovf_full", 32'(sif.full), 32'd1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 16'hDEAD, 1'b0);
    check("ovf_full_hold", 32'(sif.full), 32'd1);
`ifdef SAMPLE_HALF_FIFO_DROP_CNT_EN
    check("ovf_drop3", 32'(drop_cnt), 32'd3);
`endif

    // Simultaneous read/write at count 64: read accepted, write rejected.
    cyc(1'b1, 16'hBEEF, 1'b1);
    check("rw64_data", 32'(sif.rd_data), 32'h0AAA);
    check("rw64_full", 32'(sif.full),    32'd0);

    // Remaining 63 words come out untouched by the rejected writes.
    for (int k = 0; k < 63; k++) begin
      cyc(1'b0, '0, 1'b1);
      check("ovf_data", 32'(sif.rd_data), 32'(16'h0100 + k));
    end
    check("ovf_drained", 32'(sif.empty), 32'd1);

    // Wrap: prime 32, stream 200 through, ordering preserved across wraps.
    for (int k = 0; k < 32; k++) cyc(1'b1, DW'(16'h2000 + k), 1'b0);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, DW'(16'h2000 + 32 + i), 1'b1);
      check("wrap_data", 32'(sif.rd_data), 32'(16'h2000 + i));
    end

    // Build count to 40 in RUN, then reset mid-cycle with a read pending.
    for (int k = 0; k < 8; k++) cyc(1'b1, DW'(16'h3000 + k), 1'b0);
    check("pre_rst_above", 32'(sif.above_half), 32'd1);
    sif.rd_en = 1'b1;
    sif.wr_en = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("arst_valid", 32'(sif.rd_valid),   32'd0);
    check("arst_data",  32'(sif.rd_data),    32'd0);
    check("arst_above", 32'(sif.above_half), 32'd0);
    check("arst_ur",    32'(sif.underrun),   32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(sif.rd_valid), 32'd0);
    check("rst_hold_empty", 32'(sif.empty),    32'd1);
    sif.rd_en = 1'b0;
    sif.wr_en = 1'b0;
    rst_n = 1'b1;

    // Refill requires 32 fresh writes.
    for (int k = 0; k < 31; k++) cyc(1'b1, DW'(16'h4000 + k), 1'b0);
    check("refill31_above", 32'(sif.above_half), 32'd0);
    cyc(1'b1, 16'h401F, 1'b0);
    check("refill32_above", 32'(sif.above_half), 32'd1);
    cyc(1'b0, '0, 1'b1);
    check("refill_first", 32'(sif.rd_data), 32'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sample_half_fifo.md
SAMPLE_HALF_FIFO -- requirements
Module: sample_half_fifo

Interface
REQ-001 Parameter DATA_W, default 16, width of one sample word.
REQ-002 Parameter DEPTH, default 64, number of word slots; SHALL be a power of two, 4 or greater.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write request from the sampling side.
REQ-006 wr_data  input  DATA_W  sample to store (two's complement, not interpreted).
REQ-007 full  output  1  high when count == DEPTH.
REQ-008 rd_en  input  1  read request from the downstream consumer.
REQ-009 rd_data  output  DATA_W  registered read word.
REQ-010 rd_valid  output  1  high for one cycle when rd_data holds a newly read word.
REQ-011 empty  output  1  high when count == 0.
REQ-012 above_half  output  1  stream-enable; downstream drives its read request from this.
REQ-013 underrun  output  1  sticky flag; set on a read attempt while empty in RUN.

Function
REQ-014 Storage is a circular buffer of DEPTH words with wrapping write/read pointers and a count of width log2(DEPTH)+1.
REQ-015 A write is accepted when wr_en && !full; the word lands at the write pointer, which then increments modulo DEPTH.
REQ-016 A read is accepted when rd_en && !empty; rd_data and rd_valid update on the next clock edge (latency 1), and the read pointer increments modulo DEPTH.
REQ-017 Rejected writes (full) and rejected reads (empty) SHALL leave pointers, count and stored data unchanged.
REQ-018 A simultaneous accepted read and write SHALL leave count unchanged, including at count == DEPTH-1 and count == 1.
REQ-019 A simultaneous read and write at count == 0 SHALL reject the read and accept the write; at count == DEPTH, SHALL accept the read and reject the write.
REQ-020 The FSM has two states: FILL and RUN. In FILL, above_half = 0. In RUN, above_half = 1. above_half is a registered output.
REQ-021 The FSM moves FILL->RUN on the edge at which the post-update count reaches DEPTH/2 or more; above_half rises in that same edge.
REQ-022 RUN holds regardless of count dropping below DEPTH/2. This provides hysteresis, so the stage streams continuously once primed.
REQ-023 In RUN, rd_en while empty SHALL set underrun, return the FSM to FILL, and drop above_half on that edge; no read occurs.
REQ-024 underrun clears only on reset.
REQ-025 rd_valid is low on every cycle without an accepted read; rd_data holds its last value when no read is accepted.

Reset
REQ-026 While rst_n = 0, the block SHALL be in this state: pointers 0, count 0, FSM FILL, rd_data 0, rd_valid 0, above_half 0, underrun 0, full 0, empty 1.
REQ-027 Reset asserted mid-stream SHALL discard all stored data immediately, with no completion of an in-flight read.
REQ-028 Reset release is synchronous to clk; the first write is accepted on the first rising edge with rst_n = 1.
REQ-029 Memory contents need no reset.

Configuration
REQ-030 Macro SAMPLE_HALF_FIFO_DROP_CNT_EN.
- Defined: the block SHALL add output drop_cnt, 16 bits. It increments on each rejected write (wr_en && full) and saturates at 16'hFFFF. It resets to 0.
- Undefined: the port and counter SHALL be absent.
- All other behaviour is identical in both builds.

Verification
REQ-031 Fill test (DEPTH=64, reads held low): write 0..31 -> above_half rises on the edge of the 32nd write (count 32); it stays low after write 31.
REQ-032 Stream test: after priming, read continuously while writing one word per cycle -> the rd_data sequence is 0,1,2,... each one cycle after rd_en, with no gaps; count stays 32; above_half stays 1.
REQ-033 Overflow test: 64 writes, then 3 more with full = 1 -> count 64, data unchanged; drop_cnt = 3 when the macro is defined.
REQ-034 Underrun test: in RUN, stop writes and drain 32 words, then hold rd_en one more cycle -> underrun = 1 and above_half = 0 on that edge; rd_valid stays 0.
REQ-035 Wrap test: stream 200 words through -> pointers wrap at 64 with output order intact. Boundary cases: simultaneous read/write at count 0 leaves count 1; at count 64 leaves count 63.
REQ-036 Mid-operation reset: assert rst_n = 0 at count 40 in RUN -> all outputs match REQ-026 within the same cycle (asynchronous); refill requires 32 new writes.
